acia_fifo: RTL and testbench

- Next-generation ACIA for the 6502 bus: 8N1 UART with a run-time programmable baud divisor.
- Parametrised RX and TX FIFOs, sticky error flags, and maskable IRQ sources.
- Sits on the CPU bus as four byte registers selected by addr: 0 ctrl/status, 1 data, 2 divisor low, 3 divisor high.
- Drives the board serial pins directly.

---
 rtl/acia_pkg.sv | 31 +++
 rtl/acia_sync_fifo.sv | 60 ++++++
 rtl/acia_fifo.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_acia_fifo.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acia_pkg.sv
// Shared constants for the ACIA: CPU register map, status/control bit
// positions and the smallest usable baud divisor.
package acia_pkg;

  // CPU register addresses
  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_DATA = 2'd1;
  localparam logic [1:0] ADDR_DIVL = 2'd2;
  localparam logic [1:0] ADDR_DIVH = 2'd3;

  // Status byte bit positions
  localparam int ST_RX_NE   = 0;
  localparam int ST_TX_NF   = 1;
  localparam int ST_TX_IDLE = 2;
  localparam int ST_OVR     = 3;
  localparam int ST_FE      = 4;
  localparam int ST_RX_HALF = 5;
  localparam int ST_TXOVF   = 6;
  localparam int ST_IRQ     = 7;

  // Control byte bit positions; bits[1:0] == 2'b11 requests a soft reset
  localparam logic [1:0] CTRL_SOFT_RST = 2'b11;
  localparam int CTRL_RX_IE    = 2;
  localparam int CTRL_TX_IE    = 3;
  localparam int CTRL_FLUSH_RX = 4;
  localparam int CTRL_FLUSH_TX = 5;

  // Divisors below this leave too few clocks per bit for mid-bit sampling
  localparam int MIN_DIV = 4;

endpackage

// File: rtl/acia_sync_fifo.sv
// Single-clock FIFO with push/pop/flush. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; flush overrides everything.
module acia_sync_fifo
  import acia_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth)
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/acia_fifo.sv
// 6502-bus ACIA: 8N1 UART with programmable divisor, RX/TX FIFOs, sticky
// error flags and maskable interrupt. Four byte registers selected by addr.
module acia_fifo
  import acia_pkg::*;
#(
  parameter int CLK_FREQ     = 12000000,
  parameter int DEFAULT_BAUD = 9600,
  parameter int FIFO_DEPTH   = 16,
  parameter int DIVW         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIVW-1:0] DIV_RESET = DIVW'(CLK_FREQ / DEFAULT_BAUD);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Clamp the programmed divisor so every bit period is long enough to sample
  function automatic logic [DIVW-1:0] clamp_div(input logic [DIVW-1:0] d);
    if (d < DIVW'(MIN_DIV)) return DIVW'(MIN_DIV);
    return d;
  endfunction

  // Bus decode
  logic wr, rd, soft_rst, any_rst, stat_rd;
  assign wr       = cs & we;
  assign rd       = cs & ~we;
  assign soft_rst = wr & (addr == ADDR_CTRL) & (din[1:0] == CTRL_SOFT_RST);
  assign any_rst  = rst | soft_rst;
  assign stat_rd  = rd & (addr == ADDR_CTRL);

  // Configuration and sticky state
  logic [DIVW-1:0] div_reg, eff_div;
  logic [15:0]     div16;
  logic            rx_ie, tx_ie;
  logic            ovr_flag, fe_flag, txovf_flag;

  assign eff_div = clamp_div(div_reg);
  assign div16   = 16'(div_reg);

  // FIFO interfaces
  logic          rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [7:0]    rx_head, rx_byte;
  logic [CW-1:0] rx_count;
  logic          tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic [7:0]    tx_head;
  logic [CW-1:0] tx_count_unused;

  assign rx_pop   = rd & (addr == ADDR_DATA) & ~rx_empty;
  assign tx_push  = wr & (addr == ADDR_DATA);
  assign rx_flush = soft_rst | (wr & (addr == ADDR_CTRL) & din[CTRL_FLUSH_RX]);
  assign tx_flush = soft_rst | (wr & (addr == ADDR_CTRL) & din[CTRL_FLUSH_TX]);

  acia_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .wdata (rx_byte),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  acia_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .wdata (din),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count_unused)
  );

  // ---------------- TX engine ----------------
  logic [1:0]      tx_state;
  logic [DIVW-1:0] tx_cnt, tx_div;
  logic [2:0]      tx_bit;
  logic [7:0]      tx_shift;
  logic            tx_end, tx_shift_en;

  assign tx_end      = (tx_cnt == tx_div - DIVW'(1));
  assign tx_pop      = ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_end)) & ~tx_empty;
  assign tx_shift_en = tx_end & ((tx_state == S_START) |
                                 ((tx_state == S_DATA) & (tx_bit != 3'd7)));

  // TX control: frame sequencing and the serial line itself
  always_ff @(posedge clk) begin
    if (any_rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_pop) begin
            tx_state <= S_START;
            tx_cnt   <= '0;
            tx       <= 1'b0;
          end
        end
        S_START: begin
          if (tx_end) begin
            tx_state <= S_DATA;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx       <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + DIVW'(1);
          end
        end
        S_DATA: begin
          if (tx_end) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= S_STOP;
              tx       <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 3'd1;
              tx     <= tx_shift[0];
            end
          end else begin
            tx_cnt <= tx_cnt + DIVW'(1);
          end
        end
        S_STOP: begin
          if (tx_end) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_state <= S_START;
              tx       <= 1'b0;
            end else begin
              tx_state <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + DIVW'(1);
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // TX datapath: latch byte and rate at each start bit, then shift LSB first
  always_ff @(posedge clk) begin
    if (tx_pop) begin
      tx_shift <= tx_head;
      tx_div   <= eff_div;
    end else if (tx_shift_en) begin
      tx_shift <= {1'b0, tx_shift[7:1]};
    end
  end

  // ---------------- RX engine ----------------
  logic            rx_s1, rx_s2, rx_prev;
  logic [1:0]      rx_state;
  logic [DIVW-1:0] rx_cnt, rx_div;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_fall, rx_end, rx_half_end, fe_set, ovr_set, txovf_set;

  assign rx_fall     = rx_prev & ~rx_s2;
  assign rx_end      = (rx_cnt == rx_div - DIVW'(1));
  assign rx_half_end = (rx_cnt == (rx_div >> 1) - DIVW'(1));
  assign rx_byte     = rx_shift;
  assign rx_push     = (rx_state == S_STOP) & rx_end & rx_s2;
  assign fe_set      = (rx_state == S_STOP) & rx_end & ~rx_s2;
  assign ovr_set     = rx_push & rx_full & ~rx_pop;
  assign txovf_set   = tx_push & tx_full & ~tx_pop;

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX control: start validation at half-bit, then sample at bit centres
  always_ff @(posedge clk) begin
    if (any_rst) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (rx_fall) begin
            rx_state <= S_START;
            rx_cnt   <= '0;
          end
        end
        S_START: begin
          if (rx_half_end) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + DIVW'(1);
          end
        end
        S_DATA: begin
          if (rx_end) begin
            rx_cnt <= '0;
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + DIVW'(1);
          end
        end
        S_STOP: begin
          if (rx_end) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
          end else begin
            rx_cnt <= rx_cnt + DIVW'(1);
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // RX datapath: rate latched at the start edge, bits shifted in LSB first
  always_ff @(posedge clk) begin
    if ((rx_state == S_IDLE) && rx_fall) rx_div <= eff_div;
    if ((rx_state == S_DATA) && rx_end) rx_shift <= {rx_s2, rx_shift[7:1]};
  end

  // ---------------- Registers and status ----------------
  logic [7:0] status;

  // Assemble the status byte from registered state only
  always_comb begin
    status             = '0;
    status[ST_RX_NE]   = ~rx_empty;
    status[ST_TX_NF]   = ~tx_full;
    status[ST_TX_IDLE] = tx_empty & (tx_state == S_IDLE);
    status[ST_OVR]     = ovr_flag;
    status[ST_FE]      = fe_flag;
    status[ST_RX_HALF] = (rx_count >= CW'(FIFO_DEPTH / 2));
    status[ST_TXOVF]   = txovf_flag;
    status[ST_IRQ]     = irq;
  end

  assign irq = (rx_ie & ~rx_empty) | (tx_ie & tx_empty);

  // Divisor survives soft reset; only the hard reset reloads the default
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= DIV_RESET;
    end else if (wr && addr == ADDR_DIVL) begin
      div_reg <= DIVW'({div16[15:8], din});
    end else if (wr && addr == ADDR_DIVH) begin
      div_reg <= DIVW'({din, div16[7:0]});
    end
  end

  // Interrupt enables; flush bits act on the FIFOs and are not stored
  always_ff @(posedge clk) begin
    if (any_rst) begin
      rx_ie <= 1'b0;
      tx_ie <= 1'b0;
    end else if (wr && addr == ADDR_CTRL) begin
      rx_ie <= din[CTRL_RX_IE];
      tx_ie <= din[CTRL_TX_IE];
    end
  end

  // Sticky error flags: cleared by a status read, but a new event that cycle wins
  always_ff @(posedge clk) begin
    if (any_rst) begin
      ovr_flag   <= 1'b0;
      fe_flag    <= 1'b0;
      txovf_flag <= 1'b0;
    end else begin
      ovr_flag   <= ovr_set   | (ovr_flag   & ~stat_rd);
      fe_flag    <= fe_set    | (fe_flag    & ~stat_rd);
      txovf_flag <= txovf_set | (txovf_flag & ~stat_rd);
    end
  end

  // Registered read data, loaded only on a read cycle
  always_ff @(posedge clk) begin
    if (any_rst) begin
      dout <= 8'h00;
    end else if (rd) begin
      case (addr)
        ADDR_CTRL: dout <= status;
        ADDR_DATA: dout <= rx_empty ? 8'h00 : rx_head;
        ADDR_DIVL: dout <= div16[7:0];
        default:   dout <= div16[15:8];
      endcase
    end
  end

endmodule

// File: tb/tb_acia_fifo.sv
// Self-checking bench for acia_fifo: register table, directed serial
// sequences, and randomized traffic against a queue-based model.
module tb_acia_fifo;
  import acia_pkg::*;

  localparam int BL = 16;

  logic       clk = 1'b0;
  logic       rst, cs, we, rx;
  logic [1:0] addr;
  logic [7:0] din, dout;
  logic       tx, irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acia_fifo #(
    .CLK_FREQ(12000000), .DEFAULT_BAUD(9600), .FIFO_DEPTH(16), .DIVW(16)
  ) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout), .rx(rx), .tx(tx), .irq(irq)
  );

  typedef struct {
    logic       w;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp_dout;
    logic       exp_irq;
  } vec_t;

  vec_t       vecs[12];
  logic [7:0] bytes[18];
  logic [7:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // All bus tasks enter and leave on a falling edge
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
    d = dout;
  endtask

  task automatic status_is(input string name, input logic [7:0] exp);
    logic [7:0] s;
    bus_read(ADDR_CTRL, s);
    chk(name, s, exp);
  endtask

  // Check one complete frame; each of the 10 bit slots must hold for bl clocks
  task automatic tx_frame(input logic [7:0] b, input int bl, input bit wait_edge, input string tag);
    int n = 0;
    logic e;
    int nbad;
    if (wait_edge) begin
      while (tx !== 1'b0 && n < 4000) begin
        @(negedge clk);
        n++;
      end
      if (tx !== 1'b0) begin
        chk($sformatf("%s start-timeout", tag), tx, 0);
        return;
      end
    end
    for (int k = 0; k < 10; k++) begin
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      nbad = 0;
      for (int c = 0; c < bl; c++) begin
        if (tx !== e) nbad++;
        @(negedge clk);
      end
      chk($sformatf("%s bit%0d", tag, k), nbad, 0);
    end
  endtask

  task automatic tx_quiet(input string name, input int n);
    int lows = 0;
    for (int i = 0; i < n; i++) begin
      if (tx !== 1'b1) lows++;
      @(negedge clk);
    end
    chk(name, lows, 0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BL) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (BL) @(negedge clk);
    end
    rx = stop;
    repeat (BL) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  function automatic logic [7:0] model_status(input int qs, input bit ovr);
    logic [7:0] s;
    s = 8'h06;
    s[0] = (qs > 0);
    s[3] = ovr;
    s[5] = (qs >= 8);
    return s;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] e;
    int k, n, r;
    bit ovr_m;

    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 2'd0; din = 8'h00; rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset tx", tx, 1);
    chk("reset irq", irq, 0);

    // Register map table
    vecs[0]  = '{1'b0, ADDR_DIVL, 8'h00, 8'hE2, 1'b0};
    vecs[1]  = '{1'b0, ADDR_DIVH, 8'h00, 8'h04, 1'b0};
    vecs[2]  = '{1'b0, ADDR_CTRL, 8'h00, 8'h06, 1'b0};
    vecs[3]  = '{1'b0, ADDR_DATA, 8'h00, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, ADDR_DIVL, 8'h10, 8'h00, 1'b0};
    vecs[5]  = '{1'b1, ADDR_DIVH, 8'h00, 8'h00, 1'b0};
    vecs[6]  = '{1'b0, ADDR_DIVL, 8'h00, 8'h10, 1'b0};
    vecs[7]  = '{1'b0, ADDR_DIVH, 8'h00, 8'h00, 1'b0};
    vecs[8]  = '{1'b1, ADDR_CTRL, 8'h08, 8'h00, 1'b1};
    vecs[9]  = '{1'b0, ADDR_CTRL, 8'h00, 8'h86, 1'b1};
    vecs[10] = '{1'b1, ADDR_CTRL, 8'h00, 8'h00, 1'b0};
    vecs[11] = '{1'b0, ADDR_CTRL, 8'h00, 8'h06, 1'b0};
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].w) bus_write(vecs[i].a, vecs[i].d);
      else begin
        bus_read(vecs[i].a, d);
        chk($sformatf("vec%0d dout", i), d, vecs[i].exp_dout);
      end
      chk($sformatf("vec%0d irq", i), irq, vecs[i].exp_irq);
    end

    // Single character 0x55 at divisor 16
    bus_write(ADDR_DATA, 8'h55);
    status_is("status busy", 8'h02);
    tx_frame(8'h55, BL, 1'b1, "tx55");
    chk("tx idle level", tx, 1);
    status_is("status after tx55", 8'h06);

    // 17 bytes back-to-back fit (one in flight + 16 queued)
    for (int i = 0; i < 18; i++) bytes[i] = 8'($urandom);
    fork
      begin for (int i = 0; i < 17; i++) bus_write(ADDR_DATA, bytes[i]); end
      begin for (int i = 0; i < 17; i++) tx_frame(bytes[i], BL, i == 0, $sformatf("b2b%0d", i)); end
    join
    tx_quiet("b2b17 no extra", 3 * BL);
    status_is("status after 17", 8'h06);

    // 18 bytes: the last is dropped and txovf is raised
    fork
      begin for (int i = 0; i < 18; i++) bus_write(ADDR_DATA, bytes[i]); end
      begin for (int i = 0; i < 17; i++) tx_frame(bytes[i], BL, i == 0, $sformatf("ovf%0d", i)); end
    join
    tx_quiet("18th byte absent", 3 * BL);
    status_is("txovf set", 8'h46);
    status_is("txovf cleared", 8'h06);

    // Divisor change mid-character takes effect at the next start bit
    fork
      begin
        bus_write(ADDR_DATA, 8'h96);
        bus_write(ADDR_DATA, 8'h3C);
        repeat (30) @(negedge clk);
        bus_write(ADDR_DIVL, 8'h08);
      end
      begin
        tx_frame(8'h96, BL, 1'b1, "olddiv");
        tx_frame(8'h3C, 8, 1'b0, "newdiv");
      end
    join
    // Divisor below the minimum runs at 4 clocks per bit
    bus_write(ADDR_DIVL, 8'h02);
    bus_write(ADDR_DATA, 8'hC3);
    tx_frame(8'hC3, 4, 1'b1, "mindiv");
    bus_write(ADDR_DIVL, 8'h10);
    repeat (4) @(negedge clk);

    // Receive 0xA3 with rx interrupt
    send_rx(8'hA3, 1'b1);
    status_is("rx ne", 8'h07);
    chk("irq masked", irq, 0);
    bus_write(ADDR_CTRL, 8'h04);
    chk("irq rx", irq, 1);
    bus_read(ADDR_DATA, d);
    chk("rx A3", d, 8'hA3);
    chk("irq drop", irq, 0);
    status_is("rx empty", 8'h06);
    bus_write(ADDR_CTRL, 8'h00);

    // Fill RX FIFO, then overrun
    q.delete();
    for (int i = 0; i < 16; i++) begin
      e = 8'($urandom);
      q.push_back(e);
      send_rx(e, 1'b1);
    end
    status_is("rx full", 8'h27);
    send_rx(8'hFF, 1'b1);
    status_is("overrun set", 8'h2F);
    status_is("overrun cleared", 8'h27);
    for (int i = 0; i < 16; i++) begin
      bus_read(ADDR_DATA, d);
      chk($sformatf("rx fill%0d", i), d, q.pop_front());
    end
    status_is("rx drained", 8'h06);

    // Framing error and glitch rejection
    send_rx(8'h5A, 1'b0);
    status_is("framing error", 8'h16);
    status_is("fe cleared", 8'h06);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    status_is("glitch ignored", 8'h06);

    // Soft reset mid-transmission
    send_rx(8'h3C, 1'b1);
    bus_write(ADDR_CTRL, 8'h04);
    chk("irq before soft", irq, 1);
    bus_write(ADDR_DATA, 8'h00);
    bus_write(ADDR_DATA, 8'h00);
    repeat (40) @(negedge clk);
    chk("tx low mid char", tx, 0);
    bus_write(ADDR_CTRL, 8'h03);
    chk("soft tx high", tx, 1);
    chk("soft irq", irq, 0);
    status_is("soft status", 8'h06);
    bus_read(ADDR_DIVL, d);
    chk("soft div kept", d, 8'h10);
    tx_quiet("soft no tx", 200);

    // Randomized traffic against the queue model
    q.delete();
    ovr_m = 1'b0;
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(1, 4);
      for (int i = 0; i < k; i++) bytes[i] = 8'($urandom);
      fork
        begin for (int i = 0; i < k; i++) bus_write(ADDR_DATA, bytes[i]); end
        begin for (int i = 0; i < k; i++) tx_frame(bytes[i], BL, i == 0, $sformatf("rnd%0d_%0d", it, i)); end
      join
      n = $urandom_range(0, 8);
      for (int j = 0; j < n; j++) begin
        e = 8'($urandom);
        send_rx(e, 1'b1);
        if (q.size() < 16) q.push_back(e);
        else ovr_m = 1'b1;
      end
      r = $urandom_range(0, 4);
      for (int j = 0; j < r; j++) begin
        bus_read(ADDR_DATA, d);
        e = (q.size() > 0) ? q.pop_front() : 8'h00;
        chk($sformatf("rnd%0d rd%0d", it, j), d, e);
      end
      status_is($sformatf("rnd%0d status", it), model_status(q.size(), ovr_m));
      ovr_m = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
